// File: rtl/pid_altitude_ctrl.sv
// ---------------------------------------------------------------------------
// pid_altitude_ctrl
//   Three-stage PI altitude controller for the thrust mixer path.
//   Stage 1 registers the altitude error and the per-sample gains.
//   Stage 2 updates the saturating integrator and forms the P term.
//   Stage 3 forms the I term, adds P + I and clamps to a signed 15-bit word.
//   One sample per clock; source_data_valid pulses 3 edges after sampling.
//
//   Optional build macro: PID_ALTITUDE_ANTI_WINDUP_EN
//     When defined, the integrator holds its value for a sample whose error
//     has the same sign as the most recent output, if that output was clamped.
// ---------------------------------------------------------------------------
module pid_altitude_ctrl #(
  parameter int KP_SHIFT = 2,
  parameter int KI_SHIFT = 4,
  parameter int INT_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sink_data_valid,
  input  logic [7:0]         sink_command,
  input  logic [15:0]        sink_data,
  input  logic [7:0]         sink_kp,
  input  logic [7:0]         sink_ki,
  output logic               source_data_valid,
  output logic signed [14:0] source_pid
);

  // Error spans [-65535, +4080]: 18 signed bits hold it without overflow.
  localparam int ERR_W = 18;
  // Gains are zero-extended to 9 signed bits before multiplying.
  localparam int GAIN_W = 9;
  localparam int P_W    = ERR_W + GAIN_W;
  localparam int I_W    = INT_W + GAIN_W;
  // One guard bit above the wider term keeps P + I exact.
  localparam int SUM_W  = ((I_W > P_W) ? I_W : P_W) + 1;
  localparam int OUT_W  = 15;

  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'(16383);
  localparam logic signed [SUM_W-1:0] OUT_MIN = -SUM_W'(16384);

  // -------------------------------------------------------------------------
  // Stage 1: error and gains
  // -------------------------------------------------------------------------
  logic                    s1_valid_q;
  logic signed [ERR_W-1:0] s1_err_q;
  logic [7:0]              s1_kp_q;
  logic [7:0]              s1_ki_q;
  logic signed [ERR_W-1:0] err_d;

  // Setpoint is the coarse command scaled by 16 mm; both operands zero-extended.
  always_comb begin
    err_d = $signed({6'b0, sink_command, 4'b0}) - $signed({2'b0, sink_data});
  end

  // Capture error and gains on a qualified sample; the valid bit always advances.
  // NOTE: every clocked register uses non-blocking assignment so all stages see
  // the pre-edge values of their neighbours and the pipeline shifts in lock-step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      s1_kp_q    <= '0;
      s1_ki_q    <= '0;
    end else begin
      s1_valid_q <= sink_data_valid;
      if (sink_data_valid) begin
        s1_err_q <= err_d;
        s1_kp_q  <= sink_kp;
        s1_ki_q  <= sink_ki;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: integrator and P term
  // -------------------------------------------------------------------------
  logic                    s2_valid_q;
  logic signed [P_W-1:0]   s2_p_q;
  logic [7:0]              s2_ki_q;
  logic signed [INT_W-1:0] integ_q;
  logic signed [INT_W-1:0] integ_d;
  logic signed [INT_W:0]   integ_sum;
  logic signed [INT_W-1:0] integ_sat;
  logic                    integ_hold;
  logic signed [P_W-1:0]   p_prod;
  logic signed [P_W-1:0]   p_d;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] pid_q;

`ifdef PID_ALTITUDE_ANTI_WINDUP_EN
  logic                    out_sat_q;
  logic                    out_sat_d;

  // Hold while the last output was clamped and this error pushes the same way.
  always_comb begin
    integ_hold = out_sat_q && (s1_err_q != '0) && (s1_err_q[ERR_W-1] == pid_q[OUT_W-1]);
  end
`else
  // Without anti-windup the integrator is limited only by its own clamp.
  always_comb begin
    integ_hold = 1'b0;
  end
`endif

  // Saturating integrator update; the extra sum bit detects overflow exactly.
  // NOTE: each combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(s1_err_q);
    integ_sat = integ_sum[INT_W-1:0];
    if (integ_sum[INT_W] != integ_sum[INT_W-1]) begin
      integ_sat = integ_sum[INT_W] ? INT_MIN : INT_MAX;
    end
    integ_d = integ_q;
    if (s1_valid_q && !integ_hold) begin
      integ_d = integ_sat;
    end
  end

  // Proportional term: 9x18 signed product then arithmetic shift (floors).
  always_comb begin
    p_prod = $signed({1'b0, s1_kp_q}) * s1_err_q;
    p_d    = p_prod >>> KP_SHIFT;
  end

  // Stage-2 registers; integ_q then holds integrator_new for stage 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_ki_q    <= '0;
      integ_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      integ_q    <= integ_d;
      if (s1_valid_q) begin
        s2_p_q  <= p_d;
        s2_ki_q <= s1_ki_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: I term, sum and output clamp
  // -------------------------------------------------------------------------
  logic signed [I_W-1:0]   i_prod;
  logic signed [I_W-1:0]   i_term;
  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] pid_d;
  logic                    pid_clamped;

  // integ_q is read before this edge's update, so it belongs to the stage-3 sample.
  always_comb begin
    i_prod      = $signed({1'b0, s2_ki_q}) * integ_q;
    i_term      = i_prod >>> KI_SHIFT;
    sum         = SUM_W'(i_term) + SUM_W'(s2_p_q);
    pid_d       = sum[OUT_W-1:0];
    pid_clamped = 1'b0;
    if (sum > OUT_MAX) begin
      pid_d       = OUT_MAX[OUT_W-1:0];
      pid_clamped = 1'b1;
    end else if (sum < OUT_MIN) begin
      pid_d       = OUT_MIN[OUT_W-1:0];
      pid_clamped = 1'b1;
    end
  end

`ifdef PID_ALTITUDE_ANTI_WINDUP_EN
  always_comb begin
    out_sat_d = pid_clamped;
  end

  // Remember whether the most recent output was clamped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sat_q <= 1'b0;
    end else if (s2_valid_q) begin
      out_sat_q <= out_sat_d;
    end
  end
`endif

  // Output register: one-cycle valid pulse, value held between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      pid_q       <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        pid_q <= pid_d;
      end
    end
  end

  assign source_data_valid = out_valid_q;
  assign source_pid        = pid_q;

  // The clamp flag only feeds anti-windup; keep it referenced in both builds.
  logic unused_clamped;
  assign unused_clamped = pid_clamped;

endmodule

// File: tb/tb_pid_altitude_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pid_altitude_ctrl
//   Directed vectors with hand-computed results for pid_altitude_ctrl, plus
//   streamed sequences for back-to-back saturation and integrator clamping.
// ---------------------------------------------------------------------------
module tb_pid_altitude_ctrl;

  logic        clk;
  logic        reset;
  logic        sink_data_valid;
  logic [7:0]  sink_command;
  logic [15:0] sink_data;
  logic [7:0]  sink_kp;
  logic [7:0]  sink_ki;
  logic        source_data_valid;
  logic signed [14:0] source_pid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  kp;
    logic [7:0]  ki;
    int          exp_pid;
  } vec_t;

  vec_t vecs[6];

  pid_altitude_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .sink_data_valid   (sink_data_valid),
    .sink_command      (sink_command),
    .sink_data         (sink_data),
    .sink_kp           (sink_kp),
    .sink_ki           (sink_ki),
    .source_data_valid (source_data_valid),
    .source_pid        (source_pid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d,
                       input logic [7:0] kp, input logic [7:0] ki);
    sink_data_valid = v;
    sink_command    = c;
    sink_data       = d;
    sink_kp         = kp;
    sink_ki         = ki;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #100;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pulses;
    int j;
    int exp_pid;
    int n_long;

    // Running integrator: 10, 20, 30, 40, then -6 -> 34, then -7 -> 27.
    vecs[0] = '{8'd60, 16'd950, 8'd100, 8'd0,  250};   // P only
    vecs[1] = '{8'd60, 16'd950, 8'd100, 8'd16, 270};   // I = 320>>>4 = 20
    vecs[2] = '{8'd60, 16'd950, 8'd100, 8'd0,  250};   // gain not remembered
    vecs[3] = '{8'd60, 16'd950, 8'd100, 8'd2,  255};   // I = 80>>>4 = 5
    vecs[4] = '{8'd59, 16'd950, 8'd100, 8'd16, -116};  // P = -150, I = 544>>>4 = 34
    vecs[5] = '{8'd59, 16'd951, 8'd1,   8'd0,  -2};    // -7>>>2 floors to -2

    reset = 1'b1;
    drive(1'b0, 8'd0, 16'd0, 8'd0, 8'd0);
    do_reset();
    check("reset_valid", int'(source_data_valid), 0);
    check("reset_pid", int'(source_pid), 0);

    // In-flight sample discarded by a mid-pipeline reset.
    @(negedge clk);
    drive(1'b1, 8'd200, 16'd0, 8'd255, 8'd255);
    @(negedge clk);
    drive(1'b0, 8'd0, 16'd0, 8'd0, 8'd0);
    #2 reset = 1'b0;
    #20;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (source_data_valid) pulses++;
    end
    check("midreset_pulses", pulses, 0);
    check("midreset_pid", int'(source_pid), 0);

    // Table: one sample at a time, checking latency and hold.
    for (int v = 0; v < 6; v++) begin
      drive(1'b1, vecs[v].cmd, vecs[v].data, vecs[v].kp, vecs[v].ki);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) drive(1'b0, 8'd0, 16'd0, 8'd0, 8'd0);
        check($sformatf("vec%0d_valid_c%0d", v, k), int'(source_data_valid), (k == 3) ? 1 : 0);
        if (k >= 3) check($sformatf("vec%0d_pid_c%0d", v, k), int'(source_pid), vecs[v].exp_pid);
      end
    end

    // Back-to-back positive saturation then large negative error.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 4)       drive(1'b1, 8'd255, 16'd0, 8'd255, 8'd0);
      else if (i == 4) drive(1'b1, 8'd0, 16'd65535, 8'd255, 8'd0);
      else             drive(1'b0, 8'd0, 16'd0, 8'd0, 8'd0);
      @(negedge clk);
      j = i - 2;
      check($sformatf("sat_valid_%0d", i), int'(source_data_valid), (j >= 0 && j <= 4) ? 1 : 0);
      if (j >= 0 && j <= 4) begin
        exp_pid = (j < 4) ? 16383 : -16384;
        check($sformatf("sat_pid_%0d", j), int'(source_pid), exp_pid);
      end
    end

    // Integrator driven far negative through its clamp; any wrap flips the sign.
    do_reset();
    n_long = 140;
    pulses = 0;
    for (int i = 0; i < n_long + 3; i++) begin
      if (i < n_long) drive(1'b1, 8'd0, 16'd65535, 8'd0, 8'd1);
      else            drive(1'b0, 8'd0, 16'd0, 8'd0, 8'd0);
      @(negedge clk);
      j = i - 2;
      if (j >= 0 && j < n_long) begin
        check($sformatf("long_valid_%0d", j), int'(source_data_valid), 1);
        case (j)
          0:       exp_pid = -4096;
          1:       exp_pid = -8192;
          2:       exp_pid = -12288;
          default: exp_pid = -16384;
        endcase
        check($sformatf("long_pid_%0d", j), int'(source_pid), exp_pid);
      end else if (source_data_valid) begin
        pulses++;
      end
    end
    check("long_extra_pulses", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
